// File: rtl/uart_pkg.sv
// Shared UART definitions: parity-mode constants, transmitter FSM state
// encoding and a frame-length helper that the TX and RX blocks both use.
package uart_pkg;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_ODD  = 1;
    localparam int unsigned PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Clock cycles from the start-bit edge to the end of the last stop bit.
    function automatic int unsigned frame_clks(
        input int unsigned clks_per_bit,
        input int unsigned data_bits,
        input int unsigned parity,
        input int unsigned stop_bits
    );
        int unsigned par_bits;
        par_bits = (parity != PARITY_NONE) ? 1 : 0;
        return clks_per_bit * (1 + data_bits + par_bits + stop_bits);
    endfunction

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Synchronous show-ahead FIFO holding queued transmit words.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   i_wr/i_wdata write strobe and word; ignored while full
//   i_pop        remove the head word; ignored while empty
//   o_head_c     current head word (read straight from storage)
//   o_level      occupancy 0..DEPTH
//   o_full       occupancy == DEPTH
//   o_empty      occupancy == 0
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_wr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head_c,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             r_full;
    logic             r_empty;

    logic             w_wr_en;
    logic             w_pop_en;
    logic [LVL_W-1:0] w_level_nxt;

    // A write while full is dropped even if a pop frees a slot on the same edge.
    assign w_wr_en  = i_wr && !r_full;
    assign w_pop_en = i_pop && !r_empty;

    always_comb begin
        w_level_nxt = r_level;
        case ({w_wr_en, w_pop_en})
            2'b10:   w_level_nxt = r_level + LVL_W'(1);
            2'b01:   w_level_nxt = r_level - LVL_W'(1);
            default: w_level_nxt = r_level;
        endcase
    end

    // Storage needs no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop_en) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_level <= w_level_nxt;
            r_full  <= (w_level_nxt == LVL_W'(DEPTH));
            r_empty <= (w_level_nxt == '0);
        end
    end

    assign o_head_c = r_mem[r_rd_ptr];
    assign o_level  = r_level;
    assign o_full   = r_full;
    assign o_empty  = r_empty;

endmodule

// File: rtl/uart_tx_fifo.sv
// Parametrised UART transmitter with a write-side FIFO; queued words are
// sent back-to-back with no idle gap between frames.
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   data        word to queue (DATA_BITS wide, sent LSB first)
//   data_ready  write strobe; accepted when fifo_full=0
//   fifo_full   FIFO holds FIFO_DEPTH words
//   fifo_level  FIFO occupancy
//   busy        a frame is in progress
//   data_sent   one-cycle pulse at the end of each frame's final stop bit
//   tx          registered serial line, idles high
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_BITS-1:0]          data,
    input  logic                          data_ready,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy,
    output logic                          data_sent,
    output logic                          tx
);

    localparam int unsigned STOP_CLKS = STOP_BITS * CLKS_PER_BIT;
    localparam int unsigned BAUD_W    = $clog2(STOP_CLKS);
    localparam int unsigned BIT_W     = $clog2(DATA_BITS);

    localparam logic [BAUD_W-1:0] BAUD_BIT_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_STOP_LAST = BAUD_W'(STOP_CLKS - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST       = BIT_W'(DATA_BITS - 1);

    // Reject illegal configurations at elaboration.
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_fifo: DATA_BITS must be 5..9");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("uart_tx_fifo: CLKS_PER_BIT must be >= 2");
    end
    if (PARITY > PARITY_EVEN) begin : g_bad_parity
        $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
    end

    uart_state_e           r_state;
    logic [BAUD_W-1:0]     r_baud;
    logic [BIT_W-1:0]      r_bit;
    logic [DATA_BITS-1:0]  r_shift;
    logic                  r_parity;
    logic                  r_tx;
    logic                  r_busy;
    logic                  r_sent;

    logic                  w_fifo_empty;
    logic [DATA_BITS-1:0]  w_fifo_head;
    logic                  w_bit_end;
    logic                  w_frame_end;
    logic                  w_pop;
    logic                  w_head_parity;

    assign w_bit_end   = (r_baud == BAUD_BIT_LAST);
    assign w_frame_end = (r_state == ST_STOP) && (r_baud == BAUD_STOP_LAST);

    // Frames start from IDLE or chain straight out of the last stop cycle.
    assign w_pop = !w_fifo_empty && ((r_state == ST_IDLE) || w_frame_end);

    assign w_head_parity = (PARITY == PARITY_ODD) ? ~^w_fifo_head : ^w_fifo_head;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst),
        .i_wr     (data_ready),
        .i_wdata  (data),
        .i_pop    (w_pop),
        .o_head_c (w_fifo_head),
        .o_level  (fifo_level),
        .o_full   (fifo_full),
        .o_empty  (w_fifo_empty)
    );

    // Frame FSM, baud/bit counters and shift register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_baud   <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_parity <= 1'b0;
            r_tx     <= 1'b1;
            r_busy   <= 1'b0;
            r_sent   <= 1'b0;
        end else begin
            r_sent <= w_frame_end;
            if (w_pop) begin
                r_shift  <= w_fifo_head;
                r_parity <= w_head_parity;
                r_state  <= ST_START;
                r_baud   <= '0;
                r_tx     <= 1'b0;
                r_busy   <= 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_tx   <= 1'b1;
                        r_busy <= 1'b0;
                    end
                    ST_START: begin
                        if (w_bit_end) begin
                            r_state <= ST_DATA;
                            r_baud  <= '0;
                            r_bit   <= '0;
                            r_tx    <= r_shift[0];
                        end else begin
                            r_baud <= r_baud + BAUD_W'(1);
                        end
                    end
                    ST_DATA: begin
                        if (w_bit_end) begin
                            r_baud <= '0;
                            if (r_bit == BIT_LAST) begin
                                if (PARITY != PARITY_NONE) begin
                                    r_state <= ST_PARITY;
                                    r_tx    <= r_parity;
                                end else begin
                                    r_state <= ST_STOP;
                                    r_tx    <= 1'b1;
                                end
                            end else begin
                                // Next bit is shift[1] before this edge's shift lands.
                                r_bit   <= r_bit + BIT_W'(1);
                                r_shift <= r_shift >> 1;
                                r_tx    <= r_shift[1];
                            end
                        end else begin
                            r_baud <= r_baud + BAUD_W'(1);
                        end
                    end
                    ST_PARITY: begin
                        if (w_bit_end) begin
                            r_state <= ST_STOP;
                            r_baud  <= '0;
                            r_tx    <= 1'b1;
                        end else begin
                            r_baud <= r_baud + BAUD_W'(1);
                        end
                    end
                    ST_STOP: begin
                        if (w_frame_end) begin
                            r_state <= ST_IDLE;
                            r_baud  <= '0;
                            r_tx    <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_baud <= r_baud + BAUD_W'(1);
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_baud  <= '0;
                        r_tx    <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign tx        = r_tx;
    assign busy      = r_busy;
    assign data_sent = r_sent;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: three instances (no parity / even parity /
// odd parity with two stop bits) share clock, reset and write port.
module tb_uart_tx_fifo;
    import uart_pkg::*;

    localparam int CPB = 4;
    localparam int DB  = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       dr  = 1'b0;
    logic [7:0] data = 8'h00;

    logic       full_a, busy_a, sent_a, tx_a;
    logic [2:0] lvl_a;
    logic       full_b, busy_b, sent_b, tx_b;
    logic [2:0] lvl_b;
    logic       full_c, busy_c, sent_c, tx_c;
    logic [2:0] lvl_c;

    int errors = 0;
    int checks = 0;
    int n_sent = 0;

    logic [7:0] wq [8];

    always #5 clk = ~clk;

    uart_tx_fifo #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
        .clk(clk), .rst(rst), .data(data), .data_ready(dr), .fifo_full(full_a),
        .fifo_level(lvl_a), .busy(busy_a), .data_sent(sent_a), .tx(tx_a));
    uart_tx_fifo #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_b (
        .clk(clk), .rst(rst), .data(data), .data_ready(dr), .fifo_full(full_b),
        .fifo_level(lvl_b), .busy(busy_b), .data_sent(sent_b), .tx(tx_b));
    uart_tx_fifo #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) u_c (
        .clk(clk), .rst(rst), .data(data), .data_ready(dr), .fifo_full(full_c),
        .fifo_level(lvl_c), .busy(busy_c), .data_sent(sent_c), .tx(tx_c));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected tx m cycles after the write edge of a lone frame (start at m=1).
    function automatic logic exp_tx(int m, logic [7:0] d, int par, int sb);
        int nb;
        int slot;
        nb = 1 + DB + ((par != 0) ? 1 : 0) + sb;
        if (m < 1 || m > CPB * nb) return 1'b1;
        slot = (m - 1) / CPB;
        if (slot == 0) return 1'b0;
        if (slot <= DB) return d[slot-1];
        if (par != 0 && slot == DB + 1) return (par == 1) ? ~^d : ^d;
        return 1'b1;
    endfunction

    // Expected tx for n frames from wq sent back-to-back starting at m=1.
    function automatic logic exp_stream(int m, int n, int par, int sb);
        int len;
        int j;
        len = int'(frame_clks(CPB, DB, par, sb));
        if (m < 1) return 1'b1;
        j = (m - 1) / len;
        if (j >= n) return 1'b1;
        return exp_tx(m - j * len, wq[j], par, sb);
    endfunction

    initial begin
        // Reset held, then released idle
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_tx_a", 32'(tx_a), 32'd1);
            chk("rst_busy_a", 32'(busy_a), 32'd0);
            chk("rst_lvl_a", 32'(lvl_a), 32'd0);
            chk("rst_sent_a", 32'(sent_a), 32'd0);
        end
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("idle_tx_a", 32'(tx_a), 32'd1);
            chk("idle_busy_a", 32'(busy_a), 32'd0);
            chk("idle_lvl_a", 32'(lvl_a), 32'd0);
            chk("idle_full_a", 32'(full_a), 32'd0);
            chk("idle_tx_b", 32'(tx_b), 32'd1);
            chk("idle_tx_c", 32'(tx_c), 32'd1);
        end

        // Single frame 8'h5C on all three configurations
        data = 8'h5C;
        dr = 1'b1;
        @(negedge clk);
        dr = 1'b0;
        chk("single_lvl_a", 32'(lvl_a), 32'd1);
        chk("single_tx_pre", 32'(tx_a), 32'd1);
        for (int m = 1; m <= 52; m++) begin
            @(negedge clk);
            chk($sformatf("single_tx_a m=%0d", m), 32'(tx_a), 32'(exp_tx(m, 8'h5C, 0, 1)));
            chk($sformatf("single_sent_a m=%0d", m), 32'(sent_a), 32'(m == 41));
            chk($sformatf("single_busy_a m=%0d", m), 32'(busy_a), 32'(m >= 1 && m <= 40));
            chk($sformatf("even_tx_b m=%0d", m), 32'(tx_b), 32'(exp_tx(m, 8'h5C, 2, 1)));
            chk($sformatf("even_sent_b m=%0d", m), 32'(sent_b), 32'(m == 45));
            chk($sformatf("odd2_tx_c m=%0d", m), 32'(tx_c), 32'(exp_tx(m, 8'h5C, 1, 2)));
            chk($sformatf("odd2_sent_c m=%0d", m), 32'(sent_c), 32'(m == 49));
        end
        // Parity bit values for 8'h5C: even -> 0 at m=37..40, odd -> 1
        chk("even_par_bit", 32'(exp_tx(37, 8'h5C, 2, 1)), 32'd0);

        // Back-to-back: four words on consecutive edges
        wq[0] = 8'hA5; wq[1] = 8'h3C; wq[2] = 8'hFF; wq[3] = 8'h00;
        n_sent = 0;
        for (int i = 0; i < 4; i++) begin
            data = wq[i];
            dr = 1'b1;
            @(negedge clk);
            chk($sformatf("b2b_tx m=%0d", i), 32'(tx_a), 32'(exp_stream(i, 4, 0, 1)));
            chk($sformatf("b2b_full m=%0d", i), 32'(full_a), 32'd0);
        end
        dr = 1'b0;
        chk("b2b_lvl_after4", 32'(lvl_a), 32'd3);
        for (int m = 4; m <= 168; m++) begin
            @(negedge clk);
            if (sent_a) n_sent++;
            chk($sformatf("b2b_tx m=%0d", m), 32'(tx_a), 32'(exp_stream(m, 4, 0, 1)));
            chk($sformatf("b2b_sent m=%0d", m), 32'(sent_a),
                32'(m == 41 || m == 81 || m == 121 || m == 161));
        end
        chk("b2b_pulses", 32'(n_sent), 32'd4);
        chk("b2b_busy_end", 32'(busy_a), 32'd0);

        // Overflow: six writes, FIFO_DEPTH=4, one word already in flight
        wq[0] = 8'h11; wq[1] = 8'h22; wq[2] = 8'h33; wq[3] = 8'h44; wq[4] = 8'h55; wq[5] = 8'h66;
        n_sent = 0;
        for (int i = 0; i < 6; i++) begin
            data = wq[i];
            dr = 1'b1;
            @(negedge clk);
            chk($sformatf("ovf_lvl i=%0d", i), 32'(lvl_a), (i == 0) ? 32'd1 : (i >= 4 ? 32'd4 : 32'(i)));
            chk($sformatf("ovf_full i=%0d", i), 32'(full_a), 32'(i >= 4));
        end
        dr = 1'b0;
        for (int m = 6; m <= 220; m++) begin
            @(negedge clk);
            if (sent_a) n_sent++;
            chk($sformatf("ovf_tx m=%0d", m), 32'(tx_a), 32'(exp_stream(m, 5, 0, 1)));
            chk($sformatf("ovf_lvlmax m=%0d", m), 32'(lvl_a <= 3'd4), 32'd1);
        end
        chk("ovf_pulses", 32'(n_sent), 32'd5);
        chk("ovf_lvl_end", 32'(lvl_a), 32'd0);

        // Reset during DATA of the second of three queued frames
        wq[0] = 8'h96; wq[1] = 8'h69; wq[2] = 8'hC3;
        n_sent = 0;
        for (int i = 0; i < 3; i++) begin
            data = wq[i];
            dr = 1'b1;
            @(negedge clk);
        end
        dr = 1'b0;
        for (int m = 3; m <= 50; m++) begin
            @(negedge clk);
            if (sent_a) n_sent++;
            chk($sformatf("rmf_tx m=%0d", m), 32'(tx_a), 32'(exp_stream(m, 3, 0, 1)));
        end
        chk("rmf_busy_before", 32'(busy_a), 32'd1);
        chk("rmf_lvl_before", 32'(lvl_a), 32'd1);
        rst = 1'b0;
        #1;
        chk("rmf_tx_async", 32'(tx_a), 32'd1);
        chk("rmf_lvl_async", 32'(lvl_a), 32'd0);
        chk("rmf_busy_async", 32'(busy_a), 32'd0);
        chk("rmf_full_async", 32'(full_a), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (sent_a) n_sent++;
            chk("rmf_tx_held", 32'(tx_a), 32'd1);
        end
        rst = 1'b1;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (sent_a) n_sent++;
            chk($sformatf("rmf_post_tx i=%0d", i), 32'(tx_a), 32'd1);
            chk($sformatf("rmf_post_busy i=%0d", i), 32'(busy_a), 32'd0);
        end
        chk("rmf_pulses", 32'(n_sent), 32'd1);
        chk("rmf_lvl_end", 32'(lvl_a), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
